spi_reg_bridge: RTL and testbench

Parametrised SPI-slave register bridge; successor to the fixed single-register SPI decode at the top level of the roof controller. It oversamples an SPI mode-0 link from the host on osc_clk and decodes a command byte: bit 7 selects write or read, the low ADDR_W bits carry the address. It then runs burst transfers with address auto-increment over a generic one-cycle register bus. Sensor, motor and LED register files sit behind this bus instead of inline case statements.

---
 rtl/spi_bridge_pkg.sv | 13 +
 rtl/spi_edge_sync.sv | 48 ++++
 rtl/spi_reg_bridge.sv | 163 ++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI register bridge: FSM encoding, command-byte layout, default dummy byte.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    ST_CMD   = 2'd0,
    ST_WDATA = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  localparam int         CMD_WR_BIT    = 7;
  localparam logic [7:0] DUMMY_DEFAULT = 8'h5A;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the three SPI pins into osc_clk and produces single-cycle edge pulses.
// Reset parks the fss chain as "selected", so a held-low select cannot look like a fresh frame.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic osc_clk,
  input  logic rst_n,
  input  logic spi_clk,
  input  logic spi_fss,
  input  logic spi_in,
  output logic clk_rise,
  output logic fss_fall,
  output logic fss_rise,
  output logic mosi
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] fss_sync;
  logic [SYNC_STAGES-1:0] in_sync;
  logic                   clk_dly_p0;
  logic                   fss_dly_p0;
  logic                   clk_s;
  logic                   fss_s;

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync   <= '0;
      fss_sync   <= '0;
      in_sync    <= '0;
      clk_dly_p0 <= 1'b0;
      fss_dly_p0 <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      fss_sync   <= {fss_sync[SYNC_STAGES-2:0], spi_fss};
      in_sync    <= {in_sync[SYNC_STAGES-2:0], spi_in};
      clk_dly_p0 <= clk_s;
      fss_dly_p0 <= fss_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign fss_s    = fss_sync[SYNC_STAGES-1];
  assign mosi     = in_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_dly_p0 & ~fss_s;
  assign fss_fall = ~fss_s & fss_dly_p0;
  assign fss_rise = fss_s & ~fss_dly_p0;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave to one-cycle register bus bridge with command decode and burst auto-increment.
// Define SPI_BURST_EN for unlimited bursts; otherwise each command carries exactly one data byte.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int         ADDR_W      = 7,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DUMMY       = DUMMY_DEFAULT
) (
  input  logic              osc_clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_fss,
  input  logic              spi_in,
  output logic              spi_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              frame_active
);

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  logic              clk_rise;
  logic              fss_fall;
  logic              fss_rise;
  logic              mosi;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic [7:0]        rx_byte;
  logic              edge_ok;
  logic              byte_done;
  logic              wr_go;
  logic              rd_go;
  logic [ADDR_W-1:0] rd_go_addr;
  logic              tx_dummy;
  logic              rd_pend_p1;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .osc_clk (osc_clk),
    .rst_n   (rst_n),
    .spi_clk (spi_clk),
    .spi_fss (spi_fss),
    .spi_in  (spi_in),
    .clk_rise(clk_rise),
    .fss_fall(fss_fall),
    .fss_rise(fss_rise),
    .mosi    (mosi)
  );

  assign edge_ok   = clk_rise & frame_active;
  assign byte_done = edge_ok & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift, mosi};
  assign spi_out   = spi_fss ? 1'bz : tx_shift[7];

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CMD;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_go      = 1'b0;
    rd_go      = 1'b0;
    rd_go_addr = addr_q;
    tx_dummy   = 1'b0;
    if (fss_rise || fss_fall) begin
      state_d = ST_CMD;
    end else if (byte_done) begin
      case (state_q)
        ST_CMD: begin
          if (rx_byte[CMD_WR_BIT]) begin
            addr_d  = rx_byte[ADDR_W-1:0];
            state_d = ST_WDATA;
          end else begin
            rd_go      = 1'b1;
            rd_go_addr = rx_byte[ADDR_W-1:0];
            addr_d     = addr_inc(rx_byte[ADDR_W-1:0]);
            state_d    = ST_RDATA;
          end
        end
        ST_WDATA: begin
          wr_go = 1'b1;
`ifdef SPI_BURST_EN
          addr_d = addr_inc(addr_q);
`else
          state_d  = ST_CMD;
          tx_dummy = 1'b1;
`endif
        end
        ST_RDATA: begin
`ifdef SPI_BURST_EN
          // Prefetch for the byte slot that starts next.
          rd_go  = 1'b1;
          addr_d = addr_inc(addr_q);
`else
          state_d  = ST_CMD;
          tx_dummy = 1'b1;
`endif
        end
        default: state_d = ST_CMD;
      endcase
    end
  end

  // Stage p0: bus strobes one cycle after byte completion.
  // Stage p1: read data returns one cycle after rd_req and is loaded for shifting.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= 3'd0;
      rx_shift     <= 7'd0;
      tx_shift     <= DUMMY;
      frame_active <= 1'b0;
      wr_en        <= 1'b0;
      rd_req       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 8'd0;
      rd_addr      <= '0;
      rd_pend_p1   <= 1'b0;
    end else begin
      wr_en      <= wr_go;
      rd_req     <= rd_go;
      rd_pend_p1 <= rd_req;
      if (wr_go) begin
        wr_addr <= addr_q;
        wr_data <= rx_byte;
      end
      if (rd_go) rd_addr <= rd_go_addr;
      if (fss_fall)      frame_active <= 1'b1;
      else if (fss_rise) frame_active <= 1'b0;
      if (fss_rise || fss_fall) begin
        bit_cnt  <= 3'd0;
        tx_shift <= DUMMY;
      end else if (edge_ok) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte[6:0];
        tx_shift <= tx_dummy ? DUMMY : {tx_shift[6:0], 1'b0};
      end else if (rd_pend_p1) begin
        tx_shift <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge; burst scenarios run when SPI_BURST_EN is defined, legacy pairs otherwise.
module tb_spi_reg_bridge;

  localparam int HALF = 6;

  logic       osc_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       spi_clk = 1'b0;
  logic       spi_fss = 1'b1;
  logic       spi_in  = 1'b0;
  wire        spi_out;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [6:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic       frame_active;

  int checks = 0;
  int errors = 0;

  logic [6:0] wr_a[$];
  logic [7:0] wr_d[$];
  logic [6:0] rd_a[$];
  logic [7:0] miso;

  spi_reg_bridge dut (
    .osc_clk     (osc_clk),
    .rst_n       (rst_n),
    .spi_clk     (spi_clk),
    .spi_fss     (spi_fss),
    .spi_in      (spi_in),
    .spi_out     (spi_out),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_active(frame_active)
  );

  always #5 osc_clk = ~osc_clk;

  // Register file model: each register reads back as its address plus 0x40.
  always @(posedge osc_clk) if (rd_req) rd_data <= {1'b0, rd_addr} + 8'h40;

  always @(negedge osc_clk) begin
    if (wr_en) begin
      wr_a.push_back(wr_addr);
      wr_d.push_back(wr_data);
    end
    if (rd_req) rd_a.push_back(rd_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge osc_clk);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx, input int nbits);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_in = tx[i];
      wait_cyc(HALF);
      rx[i] = spi_out;
      spi_clk = 1'b1;
      wait_cyc(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    spi_fss = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic frame_end();
    wait_cyc(HALF);
    spi_fss = 1'b1;
    wait_cyc(3 * HALF);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [6:0] a, input logic [7:0] d);
    if (idx < wr_a.size()) begin
      check({tag, "_addr"}, wr_a[idx], a);
      check({tag, "_data"}, wr_d[idx], d);
    end else begin
      check({tag, "_present"}, wr_a.size(), idx + 1);
    end
  endtask

  task automatic check_rd(input string tag, input int idx, input logic [6:0] a);
    if (idx < rd_a.size()) check({tag, "_addr"}, rd_a[idx], a);
    else check({tag, "_present"}, rd_a.size(), idx + 1);
  endtask

  initial begin
    wait_cyc(3);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_wr_addr", wr_addr, 7'h00);
    check("rst_rd_addr", rd_addr, 7'h00);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_frame_active", frame_active, 1'b0);
    rst_n = 1'b1;
    wait_cyc(3 * HALF);

`ifdef SPI_BURST_EN
    frame_begin();
    check("wb_frame_active", frame_active, 1'b1);
    spi_xfer(8'h81, miso, 8);
    check("wb_miso_cmd", miso, 8'h5A);
    spi_xfer(8'h11, miso, 8);
    spi_xfer(8'h22, miso, 8);
    spi_xfer(8'h33, miso, 8);
    frame_end();
    check("wb_count", wr_a.size(), 3);
    check_wr("wb0", 0, 7'h01, 8'h11);
    check_wr("wb1", 1, 7'h02, 8'h22);
    check_wr("wb2", 2, 7'h03, 8'h33);
    check("wb_rd_count", rd_a.size(), 0);

    frame_begin();
    spi_xfer(8'h10, miso, 8);
    check("rb_miso0", miso, 8'h5A);
    spi_xfer(8'h00, miso, 8);
    check("rb_miso1", miso, 8'h50);
    spi_xfer(8'h00, miso, 8);
    check("rb_miso2", miso, 8'h51);
    frame_end();
    check("rb_count", rd_a.size(), 3);
    check_rd("rb0", 0, 7'h10);
    check_rd("rb1", 1, 7'h11);
    check_rd("rb2", 2, 7'h12);

    frame_begin();
    spi_xfer(8'hFF, miso, 8);
    spi_xfer(8'hA1, miso, 8);
    spi_xfer(8'hA2, miso, 8);
    frame_end();
    check("wrap_count", wr_a.size(), 2);
    check_wr("wrap0", 0, 7'h7F, 8'hA1);
    check_wr("wrap1", 1, 7'h00, 8'hA2);
`else
    frame_begin();
    check("lp_frame_active", frame_active, 1'b1);
    spi_xfer(8'h81, miso, 8);
    check("lp_miso_cmd", miso, 8'h5A);
    spi_xfer(8'hAA, miso, 8);
    spi_xfer(8'h05, miso, 8);
    check("lp_miso_cmd2", miso, 8'h5A);
    spi_xfer(8'h00, miso, 8);
    check("lp_miso_rd", miso, 8'h45);
    frame_end();
    check("lp_frame_idle", frame_active, 1'b0);
    check("lp_wr_count", wr_a.size(), 1);
    check_wr("lp_wr", 0, 7'h01, 8'hAA);
    check("lp_rd_count", rd_a.size(), 1);
    check_rd("lp_rd", 0, 7'h05);

    frame_begin();
    spi_xfer(8'h10, miso, 8);
    spi_xfer(8'h00, miso, 8);
    check("lr_miso1", miso, 8'h50);
    spi_xfer(8'h11, miso, 8);
    check("lr_miso_cmd2", miso, 8'h5A);
    spi_xfer(8'h00, miso, 8);
    check("lr_miso3", miso, 8'h51);
    frame_end();
    check("lr_count", rd_a.size(), 2);
    check_rd("lr0", 0, 7'h10);
    check_rd("lr1", 1, 7'h11);

    frame_begin();
    spi_xfer(8'hFF, miso, 8);
    spi_xfer(8'hA1, miso, 8);
    frame_end();
    check("wrap_count", wr_a.size(), 1);
    check_wr("wrap0", 0, 7'h7F, 8'hA1);
`endif

    frame_begin();
    spi_xfer(8'h83, miso, 8);
    spi_xfer(8'hF0, miso, 4);
    frame_end();
    check("abort_wr_count", wr_a.size(), 0);
    check("abort_rd_count", rd_a.size(), 0);

    frame_begin();
    spi_xfer(8'h02, miso, 8);
    spi_xfer(8'h00, miso, 8);
    frame_end();
    check("abort_next_miso", miso, 8'h42);
    check_rd("abort_next", 0, 7'h02);

    frame_begin();
    spi_xfer(8'h81, miso, 8);
    spi_xfer(8'h11, miso, 8);
    spi_xfer(8'h3C, miso, 4);
    check_wr("pre_rst", 0, 7'h01, 8'h11);
    rst_n = 1'b0;
    wait_cyc(2);
    check("mrst_wr_en", wr_en, 1'b0);
    check("mrst_rd_req", rd_req, 1'b0);
    check("mrst_wr_addr", wr_addr, 7'h00);
    check("mrst_rd_addr", rd_addr, 7'h00);
    check("mrst_wr_data", wr_data, 8'h00);
    check("mrst_frame_active", frame_active, 1'b0);
    check("mrst_miso", spi_out, 1'b0);
    rst_n = 1'b1;
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    wait_cyc(2);
    spi_xfer(8'h0C, miso, 4);
    spi_xfer(8'h22, miso, 8);
    spi_xfer(8'h07, miso, 8);
    wait_cyc(3 * HALF);
    check("mrst_no_wr", wr_a.size(), 0);
    check("mrst_no_rd", rd_a.size(), 0);
    check("mrst_inactive", frame_active, 1'b0);
    frame_end();

    frame_begin();
    check("post_rst_active", frame_active, 1'b1);
    spi_xfer(8'h85, miso, 8);
    check("post_rst_miso", miso, 8'h5A);
    spi_xfer(8'h77, miso, 8);
    frame_end();
    check("post_rst_count", wr_a.size(), 1);
    check_wr("post_rst", 0, 7'h05, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
